serial_rshift_unit: RTL and testbench

SERIAL_RSHIFT_UNIT -- requirements
Module: serial_rshift_unit

---
 rtl/serial_rshift_unit.sv | 98 +++++++++
 tb/tb_serial_rshift_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_rshift_unit.sv
// Purpose: iterative right shifter, one bit per cycle, logical or arithmetic fill.
// Latency: result valid min(amt,WIDTH)+1 cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; no new request accepted until back in IDLE.
module serial_rshift_unit #(
    parameter int WIDTH = 8,
    parameter int AMTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMTW-1:0]  in_amt,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    // Count must be able to hold WIDTH itself (the saturated value).
    localparam int CW = $clog2(WIDTH + 1);
    // Comparison width wide enough for both the raw amount and WIDTH.
    localparam int EW = (AMTW > CW) ? AMTW : CW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             arith_q, arith_d;

    logic [EW-1:0]    amt_ext;
    logic [EW-1:0]    wid_ext;
    logic             amt_sat;

    assign amt_ext = EW'(in_amt);
    assign wid_ext = EW'(WIDTH);
    assign amt_sat = (amt_ext >= wid_ext);

    // Handshake and status outputs decode directly from state so reset takes effect immediately.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = (state_q == ST_DONE) ? data_q : '0;

    // Next-state, count and working-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        arith_d = arith_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    arith_d = in_arith;
                    cnt_d   = amt_sat ? CW'(WIDTH) : CW'(amt_ext);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    data_d = {arith_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    cnt_d  = cnt_q - CW'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            arith_q <= arith_d;
        end
    end

endmodule

// File: tb/tb_serial_rshift_unit.sv
module tb_serial_rshift_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] in_amt;
    logic       in_arith;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    serial_rshift_unit #(.WIDTH(8), .AMTW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request through the block: check latency, result and return to IDLE.
    task automatic do_op(input string tag, input logic [7:0] d, input logic [7:0] a,
                         input logic ar, input logic [7:0] exp, input int lat);
        int n;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        in_arith  = ar;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the block must ignore them.
        in_valid = 1'b0;
        in_data  = ~d;
        in_amt   = 8'd0;
        in_arith = ~ar;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_dat"}, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_amt    = 8'h00;
        in_arith  = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("reset_outs", {28'd0, in_ready, out_valid, busy, 1'b0}, {28'd0, 4'b1000});
        chk("reset_data", 32'(out_data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // One-hot logical sweep: bit k shifted by k lands in bit 0.
        for (int k = 0; k < 8; k++) begin
            do_op($sformatf("sweep%0d", k), 8'(1 << k), 8'(k), 1'b0, 8'h01, k + 1);
        end

        do_op("a5_l1", 8'ha5, 8'd1, 1'b0, 8'h52, 2);
        do_op("a5_a1", 8'ha5, 8'd1, 1'b1, 8'hd2, 2);
        do_op("a5_l7", 8'ha5, 8'd7, 1'b0, 8'h01, 8);
        do_op("a5_a7", 8'ha5, 8'd7, 1'b1, 8'hff, 8);
        do_op("sat09_l", 8'ha5, 8'h09, 1'b0, 8'h00, 9);
        do_op("sat09_a", 8'ha5, 8'h09, 1'b1, 8'hff, 9);
        do_op("satff_l", 8'ha5, 8'hff, 1'b0, 8'h00, 9);
        do_op("satff_a", 8'ha5, 8'hff, 1'b1, 8'hff, 9);
        do_op("amt0", 8'h3c, 8'd0, 1'b0, 8'h3c, 1);
        do_op("pos_a3", 8'h70, 8'd3, 1'b1, 8'h0e, 4);

        // Backpressure: a5 >> 2 logical = 29, held for 5 cycles with a competing request.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'ha5;
        in_amt   = 8'd2;
        in_arith = 1'b0;
        @(posedge clk);
        #1;
        in_data  = 8'h11;
        in_amt   = 8'd0;
        begin
            int n;
            n = 0;
            while (!out_valid && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("bp_lat", 32'(n), 32'd3);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d", i), {22'd0, out_valid, in_ready, out_data},
                {22'd0, 1'b1, 1'b0, 8'h29});
        end
        // Release with in_valid still high: must land in IDLE, not accept.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release", {29'd0, in_ready, busy, out_valid}, 32'b100);
        in_valid = 1'b0;

        // Reset mid-shift: amount-6 shift, reset 3 cycles after accept.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hff;
        in_amt   = 8'd6;
        in_arith = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {29'd0, in_ready, out_valid, busy}, 32'b100);
        chk("mid_rst_data", 32'(out_data), 32'h00);
        begin
            int seen;
            seen = 0;
            repeat (3) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            @(negedge clk);
            rst_n = 1'b1;
            repeat (8) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("mid_no_valid", 32'(seen), 32'd0);
        end
        do_op("post_rst", 8'h80, 8'd3, 1'b0, 8'h10, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
